approx_mac_pipe: RTL and testbench
==================================

// Module: approx_mac_pipe
// PURPOSE
//  Pipelined, parametrised multiply-accumulate unit built on an approximate array multiplier.
//  Per accepted beat it computes an approximate product a*b and either starts a new sum (acc = P + c) or accumulates (acc += P).
//  Inputs and outputs use valid/ready streams. Sits between operand sources and the filter/dot-product datapath.
// PARAMETERS
//  W       16  operand width of in_a, in_b (unsigned)
//  APPROX  10  partial-product columns 0..APPROX-1 dropped; 0 = exact; legal range 0..2*W-1
//  ACC_W   40  accumulator / in_c / out_acc width; must be >= 2*W
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid && in_ready
//  in_a       in   W      multiplicand
//  in_b       in   W      multiplier
//  in_c       in   ACC_W  addend; used only when in_clr=1
//  in_clr     in   1      1: acc = P + in_c; 0: acc = acc + P
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid && out_ready
//  out_acc    out  ACC_W  accumulator value after this beat
//  out_ovf    out  1      this beat's add overflowed ACC_W bits
// BEHAVIOUR
//  - Product: P = sum of a[j]*b[i]*2^(i+j) over all i,j with i+j >= APPROX. Drop is per column, not truncation of the exact product. Zero-extend to ACC_W.
//  - Pipeline: S1 registers operands, clr and c. S2 registers P (multiplier fully inside S2). S3 is the accumulator and output register.
//  - Latency: 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat/cycle.
//  - Stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
//    When adv=0 all stages hold. When adv=1 all stages shift and bubbles propagate as valid=0.
//  - Accumulator: updates only when S2 valid && adv. Bubbles leave acc unchanged.
//    Each update sets out_acc to the new acc and out_ovf to the carry-out of the ACC_W-bit add.
//  - Unsigned arithmetic throughout. Results leave in acceptance order; none are dropped or duplicated.
//  - Reset (async, any time): all stage valids=0, out_valid=0, out_acc=0, out_ovf=0, acc=0, in_ready=1 after release.
//    In-flight beats are discarded. The first beat after reset with in_clr=0 accumulates onto 0.
//  - in_clr=1 on consecutive beats: each beat restarts the sum; no carry-over.
//  - Data inputs are don't-care when in_valid=0. out_acc and out_ovf hold while out_valid && !out_ready.
// CONFIGURATION
//  - Macro MAC_SATURATE_EN.
//  - Defined: on overflow acc and out_acc clamp to 2^ACC_W-1 and out_ovf=1. Later beats accumulate from the clamped value.
//  - Undefined: acc wraps modulo 2^ACC_W and out_ovf=1 for that beat only.
//  - No other behaviour differs between the two builds.
// TESTING
//  (instance W=16, ACC_W=40 unless stated; model is a column-masked golden product)
//  1. APPROX=0: a=3, b=5, c=7, clr=1, out_ready=1 -> 3 cycles later out_acc=22, out_ovf=0.
//  2. APPROX=10: a=0xFFFF, b=0x0001, c=0, clr=1 -> out_acc=0xFC00. Then a=b=0x0003, clr=1 -> out_acc=0.
//  3. APPROX=0 run: (2,3,clr=1,c=0), (4,5,clr=0), (1,1,clr=0) -> out_acc 6, 26, 27 on consecutive cycles.
//  4. Backpressure: stream 6 beats, hold out_ready=0 for 5 cycles -> in_ready=0 while stalled.
//     All 6 results arrive in order, none lost or repeated. Check out_acc stable during the stall.
//  5. ACC_W=32, APPROX=0: c=0xFFFFFFF0, a=b=0, clr=1, then a=0x20, b=1, clr=0.
//     Wrap build: 0x00000010 with ovf=1. MAC_SATURATE_EN build: 0xFFFFFFFF with ovf=1.
//  6. Two beats in flight, pulse rst mid-cycle -> out_valid=0 immediately, no stale output.
//     After release, a=1, b=1, clr=0 (APPROX=0) -> out_acc=1.

Source files
------------

// File: rtl/approx_mac_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// approx_mac_pipe : 3-stage valid/ready multiply-accumulate, approximate array
//                   multiplier (low APPROX columns dropped). Macro MAC_SATURATE_EN.
// Revision: 1.0
// ============================================================================
module approx_mac_pipe #(
  parameter int W      = 16,
  parameter int APPROX = 10,
  parameter int ACC_W  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [ACC_W-1:0] in_c,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam logic [2*W-1:0] c_col_mask = {(2*W){1'b1}} << APPROX;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic [ACC_W-1:0] s1_c_q, s1_c_d;
  logic             s1_clr_q, s1_clr_d;

  logic             s2_valid_q, s2_valid_d;
  logic [2*W-1:0]   s2_prod_q, s2_prod_d;
  logic [ACC_W-1:0] s2_c_q, s2_c_d;
  logic             s2_clr_q, s2_clr_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             adv;
  logic [2*W-1:0]   pp_row [W];
  logic [2*W-1:0]   prod_sum;
  logic [ACC_W-1:0] add_base;
  logic [ACC_W:0]   add_full;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Each partial-product row is masked by column, so dropped bits never carry in.
  for (genvar i = 0; i < W; i++) begin : g_pp_row
    assign pp_row[i] = s1_b_q[i] ? (({{W{1'b0}}, s1_a_q} << i) & c_col_mask) : '0;
  end

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < W; i++) begin
      prod_sum = prod_sum + pp_row[i];
    end
  end

  always_comb begin
    add_base = s2_clr_q ? s2_c_q : acc_q;
    add_full = {1'b0, add_base} + {1'b0, ACC_W'(s2_prod_q)};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    s1_clr_d    = s1_clr_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_c_d      = s2_c_q;
    s2_clr_d    = s2_clr_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_c_d   = in_c;
        s1_clr_d = in_clr;
      end
      if (s1_valid_q) begin
        s2_prod_d = prod_sum;
        s2_c_d    = s1_c_q;
        s2_clr_d  = s1_clr_q;
      end
      if (s2_valid_q) begin
        ovf_d = add_full[ACC_W];
`ifdef MAC_SATURATE_EN
        acc_d = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
`else
        acc_d = add_full[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_clr_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_c_q      <= '0;
      s2_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_clr_q    <= s1_clr_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_c_q      <= s2_c_d;
      s2_clr_q    <= s2_clr_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mac_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_approx_mac_pipe : directed vector table, reset/backpressure sequences and
//                      randomized streams against a column-masked golden model.
// Revision: 1.0
// ============================================================================
module tb_approx_mac_pipe;

  localparam int AW_A  = 40;
  localparam int APP_A = 10;
  localparam int AW_B  = 32;
  localparam int APP_B = 0;
`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_clr, a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_a, a_in_b;
  logic [39:0] a_in_c, a_out_acc;
  logic        b_in_valid, b_in_ready, b_in_clr, b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_a, b_in_b;
  logic [31:0] b_in_c, b_out_acc;

  approx_mac_pipe #(.W(16), .APPROX(APP_A), .ACC_W(AW_A)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_c(a_in_c), .in_clr(a_in_clr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf)
  );

  approx_mac_pipe #(.W(16), .APPROX(APP_B), .ACC_W(AW_B)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_c(b_in_c), .in_clr(b_in_clr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Golden product straight from the definition: keep a[j]*b[i] where i+j >= approx.
  function automatic logic [63:0] ref_prod(input int approx, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] p;
    p = 64'd0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (a[j] && b[i] && (i + j) >= approx) p = p + (64'd1 << (i + j));
    return p;
  endfunction

  task automatic ref_step(input int accw, input logic clr, input logic [63:0] c, input logic [63:0] p,
                          input logic [63:0] acc_in, output logic [63:0] acc_out, output logic ovf);
    logic [63:0] lim, full;
    lim  = 64'd1 << accw;
    full = (clr ? c : acc_in) + p;
    ovf  = (full >= lim);
    if (!ovf)     acc_out = full;
    else if (SAT) acc_out = lim - 64'd1;
    else          acc_out = full - lim;
  endtask

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [63:0] macc_a, macc_b;
  int          popped_a = 0;
  exp_t        mon_e;
  logic [63:0] mon_p, mon_n;
  logic        mon_o;

  // Scoreboard: the model advances at each accepted beat, results pop in order.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      macc_a = 64'd0;
      macc_b = 64'd0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_spurious_out: got out_valid=1 required no pending result");
        end else begin
          mon_e = qa.pop_front();
          chk("a_stream_acc", 64'(a_out_acc), mon_e.acc);
          chk("a_stream_ovf", 64'(a_out_ovf), 64'(mon_e.ovf));
          popped_a++;
        end
      end
      if (a_in_valid && a_in_ready) begin
        mon_p = ref_prod(APP_A, a_in_a, a_in_b);
        ref_step(AW_A, a_in_clr, 64'(a_in_c), mon_p, macc_a, mon_n, mon_o);
        macc_a = mon_n;
        qa.push_back('{mon_n, mon_o});
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_spurious_out: got out_valid=1 required no pending result");
        end else begin
          mon_e = qb.pop_front();
          chk("b_stream_acc", 64'(b_out_acc), mon_e.acc);
          chk("b_stream_ovf", 64'(b_out_ovf), 64'(mon_e.ovf));
        end
      end
      if (b_in_valid && b_in_ready) begin
        mon_p = ref_prod(APP_B, b_in_a, b_in_b);
        ref_step(AW_B, b_in_clr, 64'(b_in_c), mon_p, macc_b, mon_n, mon_o);
        macc_b = mon_n;
        qb.push_back('{mon_n, mon_o});
      end
    end
  end

  typedef struct {
    bit          sel;   // 0: dut_a (APPROX=10, 40b), 1: dut_b (exact, 32b)
    logic [15:0] a;
    logic [15:0] b;
    logic [39:0] c;
    logic        clr;
    logic [39:0] acc;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(input bit sel, input logic [15:0] a, input logic [15:0] b,
                              input logic [39:0] c, input logic clr, input logic [39:0] acc, input logic ovf);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.c = c; v.clr = clr; v.acc = acc; v.ovf = ovf;
    return v;
  endfunction

  task automatic send_dir(input vec_t v, input int idx);
    int          n;
    logic [63:0] acc_got;
    logic        ovf_got;
    if (v.sel) begin
      b_in_a = v.a; b_in_b = v.b; b_in_c = v.c[31:0]; b_in_clr = v.clr; b_in_valid = 1'b1;
    end else begin
      a_in_a = v.a; a_in_b = v.b; a_in_c = v.c; a_in_clr = v.clr; a_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    n = 1;
    while (!(v.sel ? b_out_valid : a_out_valid) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    acc_got = v.sel ? 64'(b_out_acc) : 64'(a_out_acc);
    ovf_got = v.sel ? b_out_ovf : a_out_ovf;
    chk($sformatf("vec%0d_latency", idx), 64'(n), 64'd3);
    chk($sformatf("vec%0d_acc", idx), acc_got, 64'(v.acc));
    chk($sformatf("vec%0d_ovf", idx), 64'(ovf_got), 64'(v.ovf));
  endtask

  vec_t        vt[13];
  logic [63:0] tmp64;
  logic [39:0] held;
  int          n;
  int          popped_base;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1, 16'd3,      16'd5,      40'd7,             1'b1, 40'd22,        1'b0);
    vt[1]  = mk(1, 16'd2,      16'd3,      40'd0,             1'b1, 40'd6,         1'b0);
    vt[2]  = mk(1, 16'd4,      16'd5,      40'h1234,          1'b0, 40'd26,        1'b0);
    vt[3]  = mk(1, 16'd1,      16'd1,      40'h55,            1'b0, 40'd27,        1'b0);
    vt[4]  = mk(1, 16'd0,      16'd0,      40'hFFFF_FFF0,     1'b1, 40'hFFFF_FFF0, 1'b0);
    vt[5]  = mk(1, 16'h20,     16'h1,      40'd0,             1'b0,
                SAT ? 40'hFFFF_FFFF : 40'h10, 1'b1);
    vt[6]  = mk(1, 16'd3,      16'd3,      40'd0,             1'b0,
                SAT ? 40'hFFFF_FFFF : 40'h19, SAT);
    vt[7]  = mk(1, 16'hFFFF,   16'hFFFF,   40'd0,             1'b1, 40'hFFFE_0001, 1'b0);
    vt[8]  = mk(0, 16'hFFFF,   16'h0001,   40'd0,             1'b1, 40'hFC00,      1'b0);
    vt[9]  = mk(0, 16'h0003,   16'h0003,   40'd0,             1'b1, 40'd0,         1'b0);
    vt[10] = mk(0, 16'h8000,   16'h8000,   40'hFF_FFFF_FFFF,  1'b1,
                SAT ? 40'hFF_FFFF_FFFF : 40'h3FFF_FFFF, 1'b1);
    vt[11] = mk(0, 16'h0400,   16'h0001,   40'd0,             1'b0,
                SAT ? 40'hFF_FFFF_FFFF : 40'h4000_03FF, SAT);
    vt[12] = mk(0, 16'h03FF,   16'h0001,   40'd5,             1'b1, 40'd5,         1'b0);

    a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_c = 0; a_in_clr = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_c = 0; b_in_clr = 0; b_out_ready = 1;

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_out_valid_a", 64'(a_out_valid), 64'd0);
    chk("reset_out_acc_a",   64'(a_out_acc),   64'd0);
    chk("reset_out_ovf_a",   64'(a_out_ovf),   64'd0);
    chk("reset_in_ready_b",  64'(b_in_ready),  64'd1);

    for (int i = 0; i < 13; i++) send_dir(vt[i], i);

    // Reset with beats in flight: the head beat is already presented when rst hits.
    b_in_a = 16'd5; b_in_b = 16'd5; b_in_c = 32'd0; b_in_clr = 1'b1; b_in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      b_in_a = b_in_a + 16'd1;
    end
    b_in_valid = 1'b0;
    chk("rst_pre_out_valid", 64'(b_out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_async_out_acc",   64'(b_out_acc),   64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale_out", 64'(b_out_valid), 64'd0);
    end
    chk("rst_in_ready", 64'(b_in_ready), 64'd1);
    send_dir(mk(1, 16'd1, 16'd1, 40'h77, 1'b0, 40'd1, 1'b0), 13);

    // Backpressure: six beats streamed, output stalled for five cycles.
    popped_base = popped_a;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int w;
          bit took;
          tmp64      = {$urandom, $urandom};
          a_in_a     = 16'($urandom);
          a_in_b     = 16'($urandom);
          a_in_c     = tmp64[39:0];
          a_in_clr   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          a_in_valid = 1'b1;
          took = 1'b0;
          w    = 0;
          while (!took && w < 30) begin
            @(negedge clk);
            took = a_in_ready;
            @(posedge clk); #1;
            w++;
          end
          if (!took) begin
            total++; bad++;
            $display("FAIL bp_accept: got in_ready=0 for %0d cycles required acceptance", w);
          end
        end
        a_in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          if (s == 0) held = a_out_acc;
          else chk("bp_acc_hold", 64'(a_out_acc), 64'(held));
          chk("bp_out_valid", 64'(a_out_valid), 64'd1);
          chk("bp_in_ready",  64'(a_in_ready),  64'd0);
          @(posedge clk);
        end
        #1 a_out_ready = 1'b1;
      end
    join
    n = 0;
    while (qa.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_result_count", 64'(popped_a - popped_base), 64'd6);

    // Randomized streams with random source gaps and sink backpressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      tmp64       = {$urandom, $urandom};
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_a      = 16'($urandom);
      a_in_b      = 16'($urandom);
      a_in_clr    = ($urandom_range(0, 3) == 0);
      a_in_c      = ($urandom_range(0, 3) == 0) ? (40'hFF_FFFF_FFFF - 40'(tmp64[15:0])) : tmp64[39:0];
      a_out_ready = ($urandom_range(0, 3) != 0);
      tmp64       = {$urandom, $urandom};
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_a      = 16'($urandom);
      b_in_b      = 16'($urandom);
      b_in_clr    = ($urandom_range(0, 3) == 0);
      b_in_c      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'(tmp64[15:0])) : tmp64[31:0];
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending_a", 64'(qa.size()), 64'd0);
    chk("drain_pending_b", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
